// File: rtl/render_pkg.sv
// Shared definitions for the sprite render sequencer: FSM state codes and
// default coordinate/colour widths.
package render_pkg;

    typedef enum logic [2:0] {
        ST_PLOT  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ERASE = 3'd2,
        ST_CHECK = 3'd3,
        ST_MOVE  = 3'd4
    } state_t;

    localparam int DEF_X_W      = 9;
    localparam int DEF_Y_W      = 8;
    localparam int DEF_COLOUR_W = 3;

    localparam logic [DEF_COLOUR_W-1:0] DEF_BG_COLOUR = 3'b000;

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned box overlap test (touching edges count).
// Coordinates are widened by one bit so box extents never wrap at the screen edge.
module box_overlap #(
    parameter int X_W = 9,
    parameter int Y_W = 8,
    parameter int AW  = 9,
    parameter int AH  = 16,
    parameter int BW  = 26,
    parameter int BH  = 4
) (
    input  logic [X_W-1:0] ax,
    input  logic [Y_W-1:0] ay,
    input  logic [X_W-1:0] bx,
    input  logic [Y_W-1:0] by,
    output logic           overlap
);

    logic [X_W:0] ax_e, bx_e;
    logic [Y_W:0] ay_e, by_e;

    assign ax_e = {1'b0, ax};
    assign bx_e = {1'b0, bx};
    assign ay_e = {1'b0, ay};
    assign by_e = {1'b0, by};

    assign overlap = (ax_e <= bx_e + (X_W+1)'(BW)) &&
                     (ax_e + (X_W+1)'(AW) >= bx_e) &&
                     (ay_e <= by_e + (Y_W+1)'(BH)) &&
                     (ay_e + (Y_W+1)'(AH) >= by_e);

endmodule

// File: rtl/sprite_render_sequencer.sv
// Plot/erase sequencer over NUM_OBJ sprites sharing one VGA write path, with
// player-vs-hazard collision checking, lives counter and latched gameover.
module sprite_render_sequencer
    import render_pkg::*;
#(
    parameter int                     NUM_OBJ   = 2,
    parameter int                     X_W       = DEF_X_W,
    parameter int                     Y_W       = DEF_Y_W,
    parameter int                     COLOUR_W  = DEF_COLOUR_W,
    parameter int                     PW        = 9,
    parameter int                     PH        = 16,
    parameter int                     HW        = 26,
    parameter int                     HH        = 4,
    parameter int                     LIVES     = 3,
    parameter logic [COLOUR_W-1:0]    BG_COLOUR = COLOUR_W'(DEF_BG_COLOUR)
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         done,
    input  logic                         want_to_move,
    input  logic                         restart,
    input  logic [NUM_OBJ*X_W-1:0]       obj_x,
    input  logic [NUM_OBJ*Y_W-1:0]       obj_y,
    input  logic [NUM_OBJ*X_W-1:0]       obj_x_final,
    input  logic [NUM_OBJ*Y_W-1:0]       obj_y_final,
    input  logic [NUM_OBJ*COLOUR_W-1:0]  obj_colour,
    output logic                         en_vga,
    output logic                         erase,
    output logic                         can_move,
    output logic [NUM_OBJ-1:0]           en_datapath,
    output logic [X_W-1:0]               x_final,
    output logic [Y_W-1:0]               y_final,
    output logic [COLOUR_W-1:0]          colour,
    output logic                         hit,
    output logic                         gameover,
    output logic [3:0]                   lives,
    output logic [2:0]                   obj_idx,
    output logic [2:0]                   state
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_OBJ - 1);

    function automatic logic [3:0] lives_dec(input logic [3:0] l);
        return (l == 4'd0) ? 4'd0 : l - 4'd1;
    endfunction

    state_t     st;
    logic [2:0] idx;
    logic [3:0] lives_q;
    logic       gameover_q, contact_q, hit_q;

    // Unpacked views padded to 8 entries so a 3-bit index is always in range.
    logic [X_W-1:0]      org_x [8];
    logic [Y_W-1:0]      org_y [8];
    logic [X_W-1:0]      pix_x [8];
    logic [Y_W-1:0]      pix_y [8];
    logic [COLOUR_W-1:0] pix_c [8];
    logic [NUM_OBJ-1:0]  hz_hit;
    logic                any_hit;

    for (genvar g = 0; g < 8; g++) begin : g_unpack
        if (g < NUM_OBJ) begin : g_obj
            assign org_x[g] = obj_x[g*X_W +: X_W];
            assign org_y[g] = obj_y[g*Y_W +: Y_W];
            assign pix_x[g] = obj_x_final[g*X_W +: X_W];
            assign pix_y[g] = obj_y_final[g*Y_W +: Y_W];
            assign pix_c[g] = obj_colour[g*COLOUR_W +: COLOUR_W];
        end else begin : g_pad
            assign org_x[g] = '0;
            assign org_y[g] = '0;
            assign pix_x[g] = '0;
            assign pix_y[g] = '0;
            assign pix_c[g] = '0;
        end
    end

    assign hz_hit[0] = 1'b0;
    for (genvar h = 1; h < NUM_OBJ; h++) begin : g_hazard
        box_overlap #(
            .X_W(X_W), .Y_W(Y_W), .AW(PW), .AH(PH), .BW(HW), .BH(HH)
        ) u_overlap (
            .ax      (org_x[0]),
            .ay      (org_y[0]),
            .bx      (org_x[h]),
            .by      (org_y[h]),
            .overlap (hz_hit[h])
        );
    end
    assign any_hit = |hz_hit;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            st         <= ST_PLOT;
            idx        <= 3'd0;
            lives_q    <= 4'(LIVES);
            gameover_q <= 1'b0;
            contact_q  <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            hit_q <= 1'b0;
            case (st)
                ST_PLOT: begin
                    if (done) begin
                        if (idx == LAST_IDX) begin
                            st  <= ST_WAIT;
                            idx <= 3'd0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (restart && gameover_q) begin
                        gameover_q <= 1'b0;
                        lives_q    <= 4'(LIVES);
                    end else if (want_to_move && !gameover_q) begin
                        st  <= ST_ERASE;
                        idx <= 3'd0;
                    end
                end
                ST_ERASE: begin
                    if (done) begin
                        if (idx == LAST_IDX) begin
                            st  <= ST_CHECK;
                            idx <= 3'd0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    // Only the rising edge of contact costs a life.
                    contact_q <= any_hit;
                    if (any_hit && !contact_q) begin
                        hit_q   <= 1'b1;
                        lives_q <= lives_dec(lives_q);
                        if (lives_q == 4'd1) gameover_q <= 1'b1;
                    end
                    st <= ST_MOVE;
                end
                ST_MOVE: begin
                    st  <= ST_PLOT;
                    idx <= 3'd0;
                end
                default: begin
                    st  <= ST_PLOT;
                    idx <= 3'd0;
                end
            endcase
        end
    end

    logic       active;
    logic [7:0] onehot;

    assign active = (st == ST_PLOT) || (st == ST_ERASE);
    assign onehot = 8'd1 << idx;

    always_comb begin
        en_vga      = 1'b0;
        erase       = 1'b0;
        can_move    = 1'b0;
        en_datapath = '0;
        x_final     = '0;
        y_final     = '0;
        colour      = '0;
        if (resetn) begin
            en_vga      = active;
            erase       = (st == ST_ERASE);
            can_move    = (st == ST_MOVE);
            en_datapath = active ? onehot[NUM_OBJ-1:0] : '0;
            x_final     = pix_x[idx];
            y_final     = pix_y[idx];
            colour      = (st == ST_ERASE) ? BG_COLOUR : pix_c[idx];
        end
    end

    assign hit      = hit_q;
    assign gameover = gameover_q;
    assign lives    = lives_q;
    assign obj_idx  = idx;
    assign state    = st;

endmodule
